// File: rtl/lsu_axi_master_pkg.sv
// rtl/lsu_axi_master_pkg.sv - shared types and constants for the LSU AXI master
// Contents: FSM state encoding, access size encoding, AXI response codes,
//           alignment check helper.
package lsu_axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  // An access is misaligned when any offset bit below its natural size is set.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for a 64-bit data bus
// Purely combinational.
// Ports: size/off/is_unsigned describe the access; wdata (right-aligned) ->
//        strb + wdata_lane; rdata (bus lanes) -> rdata_ext (right-aligned, extended).
module lsu_lane_align
  import lsu_axi_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  off,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  strb,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_ext
);

  logic [7:0]  strb_base;
  logic [63:0] rshift;
  logic [5:0]  bit_off;

  assign bit_off = {off, 3'b000};
  assign rshift  = rdata >> bit_off;

  always_comb begin
    strb_base = 8'hFF;
    rdata_ext = rshift;
    case (size)
      SZ_B: begin
        strb_base = 8'h01;
        rdata_ext = {{56{~is_unsigned & rshift[7]}}, rshift[7:0]};
      end
      SZ_H: begin
        strb_base = 8'h03;
        rdata_ext = {{48{~is_unsigned & rshift[15]}}, rshift[15:0]};
      end
      SZ_W: begin
        strb_base = 8'h0F;
        rdata_ext = {{32{~is_unsigned & rshift[31]}}, rshift[31:0]};
      end
      default: begin
        strb_base = 8'hFF;
        rdata_ext = rshift;
      end
    endcase
  end

  assign strb       = strb_base << off;
  assign wdata_lane = wdata << bit_off;

endmodule

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding AXI4-Lite initiator for LSU loads/stores
// Ports: clk/rst (sync, active-high); LSU request (req_*) with req_ready high only
//        when idle; one-cycle completion (resp_*); AXI AW/W/B and AR/R channels
//        toward the data SRAM. All outputs except req_ready are registered.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [63:0]                 req_wdata,
  output logic                        resp_valid,
  output logic [63:0]                 resp_rdata,
  output logic                        resp_err,
  output logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  output logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  input  logic                        axi_b_valid,
  output logic                        axi_b_ready,
  input  logic [1:0]                  axi_b_resp,
  output logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
  input  logic                        axi_r_valid,
  output logic                        axi_r_ready,
  input  logic [1:0]                  axi_r_resp,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data
);

  state_e                      state_q, state_d;
  logic [2:0]                  off_q, off_d;
  logic [1:0]                  size_q, size_d;
  logic                        uns_q, uns_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        ar_valid_q, ar_valid_d;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
  logic                        r_ready_q, r_ready_d;
  logic                        aw_valid_q, aw_valid_d;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic                        w_valid_q, w_valid_d;
  logic [AXI_DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
  logic                        b_ready_q, b_ready_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [63:0]                 resp_rdata_q, resp_rdata_d;
  logic                        resp_err_q, resp_err_d;

  logic                        idle;
  logic [1:0]                  al_size;
  logic [2:0]                  al_off;
  logic                        al_uns;
  logic [7:0]                  al_strb;
  logic [63:0]                 al_wdata;
  logic [63:0]                 al_rdata;
  logic [AXI_ADDR_WIDTH-1:0]   req_addr_aligned;

  assign idle             = (state_q == ST_IDLE);
  assign req_ready        = idle;
  assign req_addr_aligned = {req_addr[AXI_ADDR_WIDTH-1:3], 3'b000};

  // In IDLE the aligner sees the incoming request so W data/strobes can be
  // registered on the accept edge; afterwards it sees the latched load attributes.
  assign al_size = idle ? req_size     : size_q;
  assign al_off  = idle ? req_addr[2:0] : off_q;
  assign al_uns  = idle ? req_unsigned : uns_q;

  lsu_lane_align u_lane_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (al_uns),
    .wdata       (req_wdata),
    .rdata       (axi_r_data),
    .strb        (al_strb),
    .wdata_lane  (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    ar_valid_d   = ar_valid_q;
    ar_addr_d    = ar_addr_q;
    r_ready_d    = r_ready_q;
    aw_valid_d   = aw_valid_q;
    aw_addr_d    = aw_addr_q;
    w_valid_d    = w_valid_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    b_ready_d    = b_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          off_d        = req_addr[2:0];
          size_d       = req_size;
          uns_d        = req_unsigned;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (is_misaligned(req_size, req_addr[2:0])) begin
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = ST_DONE;
          end else if (req_we) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = req_addr_aligned;
            w_valid_d  = 1'b1;
            w_data_d   = al_wdata;
            w_strb_d   = al_strb;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = ST_WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            ar_addr_d  = req_addr_aligned;
            state_d    = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (axi_ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (axi_r_valid) begin
          r_ready_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (axi_r_resp != AXI_OKAY);
          resp_rdata_d = (axi_r_resp != AXI_OKAY) ? '0 : al_rdata;
          state_d      = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently; either order or both together.
        if (aw_valid_q && axi_aw_ready) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_valid_q && axi_w_ready) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          b_ready_d = 1'b1;
          state_d   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi_b_valid) begin
          b_ready_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (axi_b_resp != AXI_OKAY);
          resp_rdata_d = '0;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      aw_addr_q    <= '0;
      w_valid_q    <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      b_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      ar_valid_q   <= ar_valid_d;
      ar_addr_q    <= ar_addr_d;
      r_ready_q    <= r_ready_d;
      aw_valid_q   <= aw_valid_d;
      aw_addr_q    <= aw_addr_d;
      w_valid_q    <= w_valid_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      b_ready_q    <= b_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign axi_ar_valid = ar_valid_q;
  assign axi_ar_addr  = ar_addr_q;
  assign axi_r_ready  = r_ready_q;
  assign axi_aw_valid = aw_valid_q;
  assign axi_aw_addr  = aw_addr_q;
  assign axi_w_valid  = w_valid_q;
  assign axi_w_data   = w_data_q;
  assign axi_w_strb   = w_strb_q;
  assign axi_b_ready  = b_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - self-checking bench for lsu_axi_master
module tb_lsu_axi_master;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready;
  logic [63:0] axi_aw_addr, axi_w_data, axi_ar_addr, axi_r_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid, axi_b_ready, axi_ar_valid, axi_ar_ready;
  logic        axi_r_valid, axi_r_ready;
  logic [1:0]  axi_b_resp, axi_r_resp;

  int n_pass = 0;
  int n_total = 0;

  lsu_axi_master #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_resp(axi_r_resp),
    .axi_r_data(axi_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic ref_mis(input logic [63:0] addr, input logic [1:0] size);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [63:0] addr, input logic [1:0] size);
    logic [7:0] s = '0;
    for (int i = 0; i < nbytes(size); i++) s[addr[2:0] + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [63:0] addr,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] v = '0;
    int n = nbytes(size);
    int off = int'(addr[2:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- transaction driver / responder ----------------
  int          o_resp_cnt, o_resp_cyc, o_ar_first, o_viol;
  logic [63:0] o_rdata, o_ar_addr, o_aw_addr, o_w_data;
  logic [7:0]  o_strb;
  logic        o_err, o_ar_seen, o_aw_seen, o_w_seen;

  task automatic clear_axi();
    axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_resp = 0;
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_resp = 0; axi_r_data = 0;
  endtask

  task automatic run_txn(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic [1:0] resp, input int ar_wait, input int r_wait,
                         input int aw_wait, input int w_wait, input int b_wait,
                         input logic noise);
    logic ar_hs = 0, r_done = 0, aw_hs = 0, w_hs = 0, b_done = 0;
    logic ar_vp = 0, r_rp = 0, aw_vp = 0, w_vp = 0, b_rp = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, ar_hs_cyc = 0, both_cyc = 0;
    o_resp_cnt = 0; o_resp_cyc = -1; o_ar_first = -1; o_viol = 0;
    o_rdata = 'x; o_err = 1'bx; o_ar_seen = 0; o_aw_seen = 0; o_w_seen = 0;
    o_ar_addr = 'x; o_aw_addr = 'x; o_w_data = 'x; o_strb = 'x;
    @(negedge clk);
    if (!req_ready) o_viol++;
    req_valid = 1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (axi_ar_ready && ar_vp) begin ar_hs = 1; ar_hs_cyc = cyc; end
      if (axi_r_valid && r_rp) r_done = 1;
      if (axi_aw_ready && aw_vp) aw_hs = 1;
      if (axi_w_ready && w_vp) w_hs = 1;
      if (axi_b_valid && b_rp) b_done = 1;
      if (aw_hs && w_hs && both_cyc == 0) both_cyc = cyc;
      if (o_resp_cnt > 0) begin
        if (resp_valid) o_resp_cnt++;
        if (!req_ready) o_viol++;
        break;
      end
      if (resp_valid) begin
        o_resp_cnt++; o_rdata = resp_rdata; o_err = resp_err; o_resp_cyc = cyc;
      end
      if (req_ready) o_viol++;
      if (axi_ar_valid) begin
        if (!o_ar_seen) begin o_ar_seen = 1; o_ar_addr = axi_ar_addr; o_ar_first = cyc; end
        else if (axi_ar_addr !== o_ar_addr) o_viol++;
        if (ar_hs) o_viol++;
      end else if (o_ar_seen && !ar_hs) o_viol++;
      if (axi_aw_valid) begin
        if (!o_aw_seen) begin o_aw_seen = 1; o_aw_addr = axi_aw_addr; end
        else if (axi_aw_addr !== o_aw_addr) o_viol++;
        if (aw_hs) o_viol++;
      end else if (o_aw_seen && !aw_hs) o_viol++;
      if (axi_w_valid) begin
        if (!o_w_seen) begin o_w_seen = 1; o_w_data = axi_w_data; o_strb = axi_w_strb; end
        else if (axi_w_data !== o_w_data || axi_w_strb !== o_strb) o_viol++;
        if (w_hs) o_viol++;
      end else if (o_w_seen && !w_hs) o_viol++;
      if (axi_r_ready && (!ar_hs || r_done)) o_viol++;
      if (axi_b_ready && (!(aw_hs && w_hs) || b_done)) o_viol++;
      // responder drive for the coming edge
      axi_ar_ready = axi_ar_valid && !ar_hs && (ar_cnt >= ar_wait);
      if (axi_ar_valid) ar_cnt++;
      axi_r_valid = ar_hs && !r_done && (cyc - ar_hs_cyc >= r_wait);
      axi_r_data = rdata; axi_r_resp = resp;
      axi_aw_ready = axi_aw_valid && !aw_hs && (aw_cnt >= aw_wait);
      if (axi_aw_valid) aw_cnt++;
      axi_w_ready = axi_w_valid && !w_hs && (w_cnt >= w_wait);
      if (axi_w_valid) w_cnt++;
      axi_b_valid = aw_hs && w_hs && !b_done && (cyc - both_cyc >= b_wait);
      axi_b_resp = resp;
      if (noise && o_resp_cnt == 0) begin
        req_valid = 1; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      end else req_valid = 0;
      ar_vp = axi_ar_valid; r_rp = axi_r_ready; aw_vp = axi_aw_valid;
      w_vp = axi_w_valid; b_rp = axi_b_ready;
    end
    req_valid = 0;
    clear_axi();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, resp_valid,
         resp_err, resp_rdata, axi_ar_addr, axi_aw_addr, axi_w_data, axi_w_strb} !== '0)
      $display("FAIL reset.outputs got ar_v=%b aw_v=%b w_v=%b rsp_v=%b rdata=%h expected all 0",
               axi_ar_valid, axi_aw_valid, axi_w_valid, resp_valid, resp_rdata);
    else n_pass++;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset.req_ready got %b expected 1", req_ready);
    else n_pass++;
    rst = 0;
  endtask

  task automatic test_store_byte();
    run_txn(1, 64'h8000_0003, 2'd0, 0, 64'hAB, 64'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (o_aw_addr !== 64'h8000_0000) $display("FAIL store_byte.aw_addr got %h expected %h", o_aw_addr, 64'h8000_0000);
    else n_pass++;
    n_total++;
    if (o_strb !== 8'h08) $display("FAIL store_byte.strb got %h expected 08", o_strb);
    else n_pass++;
    n_total++;
    if (o_w_data !== 64'h0000_0000_AB00_0000) $display("FAIL store_byte.w_data got %h expected 00000000ab000000", o_w_data);
    else n_pass++;
    n_total++;
    if ({o_resp_cnt, o_err, o_rdata, o_ar_seen, o_viol} !== {32'd1, 1'b0, 64'h0, 1'b0, 32'd0})
      $display("FAIL store_byte.resp got cnt=%0d err=%b rdata=%h ar_seen=%b viol=%0d expected 1/0/0/0/0",
               o_resp_cnt, o_err, o_rdata, o_ar_seen, o_viol);
    else n_pass++;
  endtask

  task automatic test_load_half();
    run_txn(0, 64'h8000_0006, 2'd1, 0, 64'h0, 64'h8001_0000_0000_0000, 2'b00, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (o_rdata !== 64'hFFFF_FFFF_FFFF_8001) $display("FAIL load_half_s.rdata got %h expected ffffffffffff8001", o_rdata);
    else n_pass++;
    n_total++;
    if ({o_ar_addr, o_ar_first, o_err, o_resp_cnt, o_viol} !== {64'h8000_0000, 32'd1, 1'b0, 32'd1, 32'd0})
      $display("FAIL load_half_s.ar got addr=%h first=%0d err=%b cnt=%0d viol=%0d expected 80000000/1/0/1/0",
               o_ar_addr, o_ar_first, o_err, o_resp_cnt, o_viol);
    else n_pass++;
    run_txn(0, 64'h8000_0006, 2'd1, 1, 64'h0, 64'h8001_0000_0000_0000, 2'b00, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (o_rdata !== 64'h0000_0000_0000_8001) $display("FAIL load_half_u.rdata got %h expected 0000000000008001", o_rdata);
    else n_pass++;
  endtask

  task automatic test_delays();
    logic [63:0] rd = 64'h1122_3344_5566_7788;
    run_txn(0, 64'h8000_0014, 2'd2, 0, 64'h0, rd, 2'b00, 3, 2, 0, 0, 0, 0);
    n_total++;
    if ({o_viol, o_resp_cnt} !== {32'd0, 32'd1})
      $display("FAIL delays.protocol got viol=%0d resp_cnt=%0d expected 0/1", o_viol, o_resp_cnt);
    else n_pass++;
    n_total++;
    if (o_rdata !== ref_load(rd, 64'h8000_0014, 2'd2, 0))
      $display("FAIL delays.rdata got %h expected %h", o_rdata, ref_load(rd, 64'h8000_0014, 2'd2, 0));
    else n_pass++;
  endtask

  task automatic test_store_dword_aw_first();
    run_txn(1, 64'h8000_0028, 2'd3, 0, 64'hDEAD_BEEF_0123_4567, 64'h0, 2'b00, 0, 0, 0, 2, 1, 0);
    n_total++;
    if (o_strb !== 8'hFF) $display("FAIL store_dword.strb got %h expected ff", o_strb);
    else n_pass++;
    n_total++;
    if ({o_w_data, o_aw_addr, o_viol, o_resp_cnt, o_err} !==
        {64'hDEAD_BEEF_0123_4567, 64'h8000_0028, 32'd0, 32'd1, 1'b0})
      $display("FAIL store_dword.txn got data=%h addr=%h viol=%0d cnt=%0d err=%b",
               o_w_data, o_aw_addr, o_viol, o_resp_cnt, o_err);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    run_txn(0, 64'h8000_0002, 2'd2, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (o_ar_seen !== 1'b0 || o_aw_seen !== 1'b0)
      $display("FAIL misaligned.no_traffic got ar=%b aw=%b expected 0/0", o_ar_seen, o_aw_seen);
    else n_pass++;
    n_total++;
    if ({o_resp_cyc, o_err, o_rdata, o_resp_cnt} !== {32'd1, 1'b1, 64'h0, 32'd1})
      $display("FAIL misaligned.resp got cyc=%0d err=%b rdata=%h cnt=%0d expected 1/1/0/1",
               o_resp_cyc, o_err, o_rdata, o_resp_cnt);
    else n_pass++;
  endtask

  task automatic test_error_resp();
    run_txn(0, 64'h8000_0030, 2'd3, 0, 64'h0, 64'h1234, 2'b10, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({o_err, o_rdata} !== {1'b1, 64'h0}) $display("FAIL rd_err got err=%b rdata=%h expected 1/0", o_err, o_rdata);
    else n_pass++;
    run_txn(1, 64'h8000_0030, 2'd2, 0, 64'h55, 64'h0, 2'b11, 0, 0, 1, 0, 0, 0);
    n_total++;
    if ({o_err, o_rdata} !== {1'b1, 64'h0}) $display("FAIL wr_err got err=%b rdata=%h expected 1/0", o_err, o_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 64'h8000_0010; req_size = 2'd3; req_unsigned = 0;
    axi_ar_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 0;
      if (axi_r_ready) begin seen = 1; break; end
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL reset_mid.reach_rd_data got r_ready=%b expected 1", axi_r_ready);
    else n_pass++;
    axi_ar_ready = 0; rst = 1;
    @(negedge clk);
    n_total++;
    if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, resp_valid,
         resp_err, resp_rdata, axi_ar_addr, req_ready} !== {129'h0, 1'b0, 64'h0, 1'b1})
      $display("FAIL reset_mid.outputs got ar_v=%b r_rdy=%b rsp_v=%b ar_addr=%h req_ready=%b expected 0/0/0/0/1",
               axi_ar_valid, axi_r_ready, resp_valid, axi_ar_addr, req_ready);
    else n_pass++;
    rst = 0;
    run_txn(0, 64'h8000_0011, 2'd0, 1, 64'h0, 64'h0000_0000_0000_9A00, 2'b00, 1, 0, 0, 0, 0, 0);
    n_total++;
    if ({o_rdata, o_err, o_resp_cnt, o_viol} !== {64'h9A, 1'b0, 32'd1, 32'd0})
      $display("FAIL reset_mid.after got rdata=%h err=%b cnt=%0d viol=%0d expected 9a/0/1/0",
               o_rdata, o_err, o_resp_cnt, o_viol);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic we = 1'($urandom_range(0, 1));
      logic [1:0] size = 2'($urandom_range(0, 3));
      logic uns = 1'($urandom_range(0, 1));
      logic [63:0] addr = 64'h8000_0000 + 64'($urandom_range(0, 255));
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] rd = {$urandom, $urandom};
      logic [1:0] resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      logic mis = ref_mis(addr, size);
      logic exp_err = mis || (resp != 2'b00);
      logic [63:0] exp_rd = (exp_err || we) ? 64'h0 : ref_load(rd, addr, size, uns);
      logic [63:0] exp_a = addr & ~64'h7;
      run_txn(we, addr, size, uns, wd, rd, resp, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
      n_total++;
      if ({o_resp_cnt, o_viol} !== {32'd1, 32'd0})
        $display("FAIL rand[%0d].protocol got cnt=%0d viol=%0d expected 1/0", it, o_resp_cnt, o_viol);
      else n_pass++;
      n_total++;
      if ({o_err, o_rdata} !== {exp_err, exp_rd})
        $display("FAIL rand[%0d].resp we=%b sz=%0d addr=%h got err=%b rdata=%h expected %b/%h",
                 it, we, size, addr, o_err, o_rdata, exp_err, exp_rd);
      else n_pass++;
      n_total++;
      if (mis) begin
        if ({o_ar_seen, o_aw_seen, o_resp_cyc} !== {2'b00, 32'd1})
          $display("FAIL rand[%0d].mis got ar=%b aw=%b cyc=%0d expected 0/0/1", it, o_ar_seen, o_aw_seen, o_resp_cyc);
        else n_pass++;
      end else if (we) begin
        if ({o_ar_seen, o_aw_addr, o_strb, o_w_data} !== {1'b0, exp_a, ref_strb(addr, size), wd << (8 * addr[2:0])})
          $display("FAIL rand[%0d].store got ar=%b addr=%h strb=%h data=%h expected 0/%h/%h/%h", it, o_ar_seen,
                   o_aw_addr, o_strb, o_w_data, exp_a, ref_strb(addr, size), wd << (8 * addr[2:0]));
        else n_pass++;
      end else begin
        if ({o_aw_seen, o_ar_addr, o_ar_first} !== {1'b0, exp_a, 32'd1})
          $display("FAIL rand[%0d].load got aw=%b addr=%h first=%0d expected 0/%h/1", it, o_aw_seen,
                   o_ar_addr, o_ar_first, exp_a);
        else n_pass++;
      end
    end
  endtask

  initial begin
    req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_unsigned = 0; req_wdata = 0;
    clear_axi();
    test_reset();
    test_store_byte();
    test_load_half();
    test_delays();
    test_store_dword_aw_first();
    test_misaligned();
    test_error_resp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
